// File: rtl/seqdet_scan_ctrl.sv
// Programmable serial-pattern detector controller: latches a pattern/config on start,
// counts overlapping matches on bit a and ends the window on target, timeout or abort.
module seqdet_scan_ctrl #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] match_target,
  input  logic [TMO_W-1:0] timeout,
  input  logic             a,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timed_out,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, sr_q, win, mask;
  logic [LEN_W-1:0] len_q, fill_q, fill_inc;
  logic [CNT_W-1:0] tgt_q, cnt_q, cnt_inc;
  logic [TMO_W-1:0] tmo_q, bcnt_q, bcnt_inc;
  logic             mpulse_q, tout_q, err_q;
  logic             cfg_bad, hit, final_hit, tmo_hit;

  // Match evaluation includes the bit being sampled on this edge.
  always_comb begin
    cfg_bad   = (pat_len == '0) || (pat_len > PAT_W_L) || (match_target == '0);
    win       = {sr_q[PAT_W-2:0], a};
    mask      = ~({PAT_W{1'b1}} << len_q);
    fill_inc  = (fill_q == PAT_W_L) ? fill_q : fill_q + 1'b1;
    bcnt_inc  = (&bcnt_q) ? bcnt_q : bcnt_q + 1'b1;
    cnt_inc   = cnt_q + 1'b1;
    hit       = (fill_inc >= len_q) && (((win ^ pat_q) & mask) == '0);
    final_hit = hit && (cnt_inc == tgt_q);
    tmo_hit   = (tmo_q != '0) && (bcnt_inc == tmo_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = cfg_bad ? DONE : SCAN;
      SCAN: begin
        if (abort)                      state_d = IDLE;
        else if (final_hit || tmo_hit)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SCAN);
    done = (state_q == DONE);
  end

  assign match_pulse = mpulse_q;
  assign match_cnt   = cnt_q;
  assign timed_out   = tout_q;
  assign err         = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q    <= '0;
      len_q    <= '0;
      tgt_q    <= '0;
      tmo_q    <= '0;
      sr_q     <= '0;
      fill_q   <= '0;
      bcnt_q   <= '0;
      cnt_q    <= '0;
      mpulse_q <= 1'b0;
      tout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      mpulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_q  <= pat_in;
            len_q  <= pat_len;
            tgt_q  <= match_target;
            tmo_q  <= timeout;
            sr_q   <= '0;
            fill_q <= '0;
            bcnt_q <= '0;
            cnt_q  <= '0;
            tout_q <= 1'b0;
            err_q  <= cfg_bad;
          end
        end
        SCAN: begin
          // abort freezes everything, so a same-edge match is neither counted nor pulsed
          if (!abort) begin
            sr_q   <= win;
            fill_q <= fill_inc;
            bcnt_q <= bcnt_inc;
            if (hit) begin
              cnt_q    <= cnt_inc;
              mpulse_q <= 1'b1;
            end
            if (tmo_hit && !final_hit) tout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
